sva_attempt_scheduler: RTL and testbench

- Dispatches overlapping assertion attempts onto a pool of NUM_SLOTS identical single-attempt checker FSMs (the generated *_checker_rtl instances); one attempt per slot.
- On each antecedent trigger, allocates a free slot round-robin and pulses its start.
- Tracks slot ownership, collects per-slot pass/fail, and keeps saturating result counters plus a sticky first-failure record for the bench/scoreboard.

---
 rtl/sva_attempt_scheduler_if.sv | 24 ++
 rtl/sva_attempt_scheduler.sv | 151 +++++++++++++++
 tb/tb_sva_attempt_scheduler.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/sva_attempt_scheduler_if.sv
// rtl/sva_attempt_scheduler_if.sv - start/abort/pass/fail bus between the scheduler and its checker slots
// Bit i of each vector belongs to checker slot i.
interface sva_attempt_scheduler_if #(
   parameter int NUM_SLOTS = 4
);
   logic [NUM_SLOTS-1:0] slot_start;
   logic [NUM_SLOTS-1:0] slot_abort;
   logic [NUM_SLOTS-1:0] slot_pass;
   logic [NUM_SLOTS-1:0] slot_fail;

   modport master (
      output slot_start,
      output slot_abort,
      input  slot_pass,
      input  slot_fail
   );

   modport slave (
      input  slot_start,
      input  slot_abort,
      output slot_pass,
      output slot_fail
   );
endinterface

// File: rtl/sva_attempt_scheduler.sv
// rtl/sva_attempt_scheduler.sv - round-robin dispatch of assertion attempts onto checker slots
// Per-slot timeout abort is built only when SVA_SCHED_TIMEOUT_EN is defined.
module sva_attempt_scheduler #(
   parameter int NUM_SLOTS  = 4,
   parameter int CNT_W      = 8,
   parameter int SLOT_IDX_W = $clog2(NUM_SLOTS),
   parameter int TIMEOUT    = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable_i,
   input  logic                  clear_i,
   input  logic                  trigger_i,
   sva_attempt_scheduler_if.master slots,
   output logic                  busy_o,
   output logic                  overflow_o,
   output logic [CNT_W-1:0]      pass_count_o,
   output logic [CNT_W-1:0]      fail_count_o,
   output logic [CNT_W-1:0]      drop_count_o,
   output logic                  first_fail_valid_o,
   output logic [SLOT_IDX_W-1:0] first_fail_slot_o
);
   typedef logic [NUM_SLOTS-1:0] mask_t;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   mask_t                 owned_q, owned_d, start_q, start_d, abort_q, abort_d;
   logic [SLOT_IDX_W-1:0] ptr_q, ptr_d, ff_slot_q, ff_slot_d;
   logic [CNT_W-1:0]      pass_cnt_q, pass_cnt_d, fail_cnt_q, fail_cnt_d, drop_cnt_q, drop_cnt_d;
   logic                  overflow_q, overflow_d, ff_valid_q, ff_valid_d;
   mask_t                 done_pass, done_fail, expired;
   logic                  alloc_ok, fire;
   logic [SLOT_IDX_W-1:0] alloc_idx, ff_pick;
   int                    idx;

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input int n);
      logic [CNT_W+4:0] s;
      s = {5'd0, a} + (CNT_W+5)'(n);
      return (s > {5'd0, CNT_MAX}) ? CNT_MAX : s[CNT_W-1:0];
   endfunction

`ifdef SVA_SCHED_TIMEOUT_EN
   localparam int AGE_W = $clog2(TIMEOUT + 1);
   logic [AGE_W-1:0] age_q [NUM_SLOTS];

   // Age is held at zero while free, so it starts from zero on the allocating edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_SLOTS; i++) age_q[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_SLOTS; i++) begin
            if (clear_i || !owned_q[i] || expired[i]) age_q[i] <= '0;
            else                                      age_q[i] <= age_q[i] + AGE_W'(1);
         end
      end
   end

   always_comb begin
      expired = '0;
      for (int i = 0; i < NUM_SLOTS; i++)
         expired[i] = owned_q[i] && (age_q[i] == AGE_W'(TIMEOUT - 1))
                      && !slots.slot_pass[i] && !slots.slot_fail[i];
   end
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT != 0);
   assign expired = '0;
`endif

   always_comb begin
      done_fail = (slots.slot_fail & owned_q) | expired;
      done_pass = slots.slot_pass & owned_q & ~slots.slot_fail;
      fire      = trigger_i && enable_i;

      // Search from ptr over the registered free mask; same-cycle releases are not visible.
      alloc_ok  = 1'b0;
      alloc_idx = '0;
      idx       = 0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         idx = int'(ptr_q) + i;
         if (idx >= NUM_SLOTS) idx = idx - NUM_SLOTS;
         if (!alloc_ok && !owned_q[SLOT_IDX_W'(idx)]) begin
            alloc_ok  = 1'b1;
            alloc_idx = SLOT_IDX_W'(idx);
         end
      end

      ff_pick = '0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--)
         if (done_fail[i]) ff_pick = SLOT_IDX_W'(i);

      owned_d    = owned_q & ~(done_pass | done_fail);
      start_d    = '0;
      abort_d    = expired;
      ptr_d      = ptr_q;
      drop_cnt_d = drop_cnt_q;
      overflow_d = overflow_q;
      if (fire && alloc_ok) begin
         owned_d[alloc_idx] = 1'b1;
         start_d[alloc_idx] = 1'b1;
         ptr_d = (int'(alloc_idx) == NUM_SLOTS - 1) ? '0 : alloc_idx + SLOT_IDX_W'(1);
      end else if (fire) begin
         drop_cnt_d = sat_add(drop_cnt_q, 1);
         overflow_d = 1'b1;
      end

      pass_cnt_d = sat_add(pass_cnt_q, $countones(done_pass));
      fail_cnt_d = sat_add(fail_cnt_q, $countones(done_fail));
      ff_valid_d = ff_valid_q;
      ff_slot_d  = ff_slot_q;
      if (!ff_valid_q && (done_fail != '0)) begin
         ff_valid_d = 1'b1;
         ff_slot_d  = ff_pick;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst || clear_i) begin
         owned_q    <= '0;
         start_q    <= '0;
         abort_q    <= '0;
         ptr_q      <= '0;
         pass_cnt_q <= '0;
         fail_cnt_q <= '0;
         drop_cnt_q <= '0;
         overflow_q <= 1'b0;
         ff_valid_q <= 1'b0;
         ff_slot_q  <= '0;
      end else begin
         owned_q    <= owned_d;
         start_q    <= start_d;
         abort_q    <= abort_d;
         ptr_q      <= ptr_d;
         pass_cnt_q <= pass_cnt_d;
         fail_cnt_q <= fail_cnt_d;
         drop_cnt_q <= drop_cnt_d;
         overflow_q <= overflow_d;
         ff_valid_q <= ff_valid_d;
         ff_slot_q  <= ff_slot_d;
      end
   end

   assign slots.slot_start   = start_q;
   assign slots.slot_abort   = abort_q;
   assign busy_o             = |owned_q;
   assign overflow_o         = overflow_q;
   assign pass_count_o       = pass_cnt_q;
   assign fail_count_o       = fail_cnt_q;
   assign drop_count_o       = drop_cnt_q;
   assign first_fail_valid_o = ff_valid_q;
   assign first_fail_slot_o  = ff_slot_q;
endmodule

// File: tb/tb_sva_attempt_scheduler.sv
// tb/tb_sva_attempt_scheduler.sv - scoreboard bench for sva_attempt_scheduler (NUM_SLOTS=4, CNT_W=8)
module tb_sva_attempt_scheduler;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       enable = 1'b1;
   logic       clear = 1'b0;
   logic       trigger = 1'b0;
   logic       busy, overflow, ff_valid;
   logic [7:0] pass_count, fail_count, drop_count;
   logic [1:0] ff_slot;

   int         checks = 0;
   int         failures = 0;
   logic [3:0] exp_q[$];
   logic [3:0] exp_v;
   logic [3:0] one_hot;
   int         lat;

   sva_attempt_scheduler_if #(.NUM_SLOTS(4)) slots ();

   sva_attempt_scheduler #(.NUM_SLOTS(4), .CNT_W(8), .TIMEOUT(16)) dut (
      .clk                (clk),
      .rst                (rst),
      .enable_i           (enable),
      .clear_i            (clear),
      .trigger_i          (trigger),
      .slots              (slots),
      .busy_o             (busy),
      .overflow_o         (overflow),
      .pass_count_o       (pass_count),
      .fail_count_o       (fail_count),
      .drop_count_o       (drop_count),
      .first_fail_valid_o (ff_valid),
      .first_fail_slot_o  (ff_slot)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      cycle();
      clear = 1'b0;
   endtask

   // Start pulses are popped against the expected one-hot queue on the falling edge.
   always @(negedge clk) begin
      if (!rst && slots.slot_start != 4'b0000) begin
         if (exp_q.size() == 0) begin
            check("start_unexpected", 32'(slots.slot_start), 32'h0);
         end else begin
            exp_v = exp_q.pop_front();
            check("start_slot", 32'(slots.slot_start), 32'(exp_v));
         end
      end
`ifndef SVA_SCHED_TIMEOUT_EN
      if (!rst && slots.slot_abort != 4'b0000)
         check("abort_unexpected", 32'(slots.slot_abort), 32'h0);
`endif
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      slots.slot_pass = 4'b0000;
      slots.slot_fail = 4'b0000;
      repeat (2) cycle();
      rst = 1'b0;
      check("rst_busy", 32'(busy), 0);
      check("rst_overflow", 32'(overflow), 0);
      check("rst_pass", 32'(pass_count), 0);
      check("rst_fail", 32'(fail_count), 0);
      check("rst_drop", 32'(drop_count), 0);
      check("rst_ffv", 32'(ff_valid), 0);
      check("rst_start", 32'(slots.slot_start), 0);

      // Single attempt, passing three cycles after its start.
      exp_q.push_back(4'b0001);
      trigger = 1'b1; cycle(); trigger = 1'b0;
      check("single_busy", 32'(busy), 1);
      cycle(); cycle();
      slots.slot_pass = 4'b0001; cycle(); slots.slot_pass = 4'b0000;
      check("single_pass", 32'(pass_count), 1);
      check("single_idle", 32'(busy), 0);

      enable = 1'b0;
      trigger = 1'b1; cycle(); trigger = 1'b0;
      enable = 1'b1;
      cycle();
      check("disabled_drop", 32'(drop_count), 0);
      check("disabled_busy", 32'(busy), 0);

      do_clear();
      check("clear_pass", 32'(pass_count), 0);

      // Five back-to-back triggers: four allocations then a drop.
      exp_q.push_back(4'b0001); exp_q.push_back(4'b0010);
      exp_q.push_back(4'b0100); exp_q.push_back(4'b1000);
      trigger = 1'b1;
      repeat (5) cycle();
      trigger = 1'b0;
      check("burst_drop", 32'(drop_count), 1);
      check("burst_overflow", 32'(overflow), 1);
      check("burst_busy", 32'(busy), 1);

      slots.slot_fail = 4'b0110; cycle(); slots.slot_fail = 4'b0000;
      check("dual_fail_cnt", 32'(fail_count), 2);
      check("dual_fail_slot", 32'(ff_slot), 1);
      check("dual_fail_valid", 32'(ff_valid), 1);
      slots.slot_fail = 4'b0001; cycle(); slots.slot_fail = 4'b0000;
      check("later_fail_cnt", 32'(fail_count), 3);
      check("later_fail_slot", 32'(ff_slot), 1);

      // Refill 0..2; release slot 3 alongside a trigger, which must drop.
      exp_q.push_back(4'b0001); exp_q.push_back(4'b0010); exp_q.push_back(4'b0100);
      trigger = 1'b1;
      repeat (3) cycle();
      slots.slot_pass = 4'b1000;
      cycle();
      slots.slot_pass = 4'b0000;
      check("release_drop", 32'(drop_count), 2);
      exp_q.push_back(4'b1000);
      cycle();
      trigger = 1'b0;
      check("release_pass", 32'(pass_count), 1);
      check("release_busy", 32'(busy), 1);

      slots.slot_pass = 4'b0100; cycle(); slots.slot_pass = 4'b0000;
      check("own_pass", 32'(pass_count), 2);
      slots.slot_pass = 4'b0100; cycle(); slots.slot_pass = 4'b0000;
      check("unowned_pass", 32'(pass_count), 2);
      slots.slot_pass = 4'b0010; slots.slot_fail = 4'b0010; cycle();
      slots.slot_pass = 4'b0000; slots.slot_fail = 4'b0000;
      check("pf_same_fail", 32'(fail_count), 4);
      check("pf_same_pass", 32'(pass_count), 2);
      slots.slot_pass = 4'b1001; cycle(); slots.slot_pass = 4'b0000;
      check("multi_pass", 32'(pass_count), 4);
      check("multi_idle", 32'(busy), 0);

      // Saturation: 300 allocate/pass rounds rotating through the slots.
      do_clear();
      for (int i = 0; i < 300; i++) begin
         one_hot = 4'b0001 << (i % 4);
         exp_q.push_back(one_hot);
         trigger = 1'b1; cycle(); trigger = 1'b0;
         slots.slot_pass = 4'b1111; cycle(); slots.slot_pass = 4'b0000;
         if (i == 253) check("sat_before", 32'(pass_count), 254);
      end
      check("sat_pass", 32'(pass_count), 255);
      check("sat_fail", 32'(fail_count), 0);

`ifdef SVA_SCHED_TIMEOUT_EN
      do_clear();
      exp_q.push_back(4'b0001);
      trigger = 1'b1; cycle(); trigger = 1'b0;
      lat = 0;
      while (slots.slot_abort == 4'b0000 && lat < 40) begin
         cycle();
         lat++;
      end
      check("to_latency", 32'(lat), 16);
      check("to_abort", 32'(slots.slot_abort), 32'h1);
      check("to_fail", 32'(fail_count), 1);
      check("to_idle", 32'(busy), 0);
      check("to_ffv", 32'(ff_valid), 1);
      cycle();
      check("to_abort_pulse", 32'(slots.slot_abort), 0);

      do_clear();
      exp_q.push_back(4'b0001);
      trigger = 1'b1; cycle(); trigger = 1'b0;
      repeat (15) cycle();
      slots.slot_pass = 4'b0001; cycle(); slots.slot_pass = 4'b0000;
      check("to_race_abort", 32'(slots.slot_abort), 0);
      check("to_race_pass", 32'(pass_count), 1);
      check("to_race_fail", 32'(fail_count), 0);
`endif

      cycle(); cycle();
      check("start_queue_empty", 32'(exp_q.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
